video_stream_gen: RTL and testbench

- Parametrised AXI4-Stream video pattern source, in the pixel_clk domain, feeding the AXI4S-to-Video-Out bridge.
- Owns its own x/y counters, which advance only on stream handshakes. Output stays correct under arbitrary tready backpressure.
- Renders a solid background, N rectangles (sprites), colour bars or a checkerboard.
- Mode, colours and rectangle geometry are latched once per frame, so no tearing occurs.

---
 rtl/video_stream_gen.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_video_stream_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// ---------------------------------------------------------------------------
// video_stream_gen
//
// AXI4-Stream video pattern source in the pixel_clk domain. Produces one
// H_ACTIVE x V_ACTIVE frame per run request, rendering a solid background,
// NUM_RECTS rectangles, 8 colour bars or a checkerboard. The pattern
// configuration is captured once per frame so a frame never tears.
//
// Ports:
//   pixel_clk    pixel clock
//   reset        asynchronous, active-high reset
//   enable       run request, sampled only when a frame is about to start
//   mode         0 solid, 1 rects, 2 colour bars, 3 checkerboard
//   bg_color     RGB444 background
//   fg_color     RGB444 rectangle / checker foreground
//   rect_en      per-rectangle enable
//   rect_x/y     packed top-left corners, rect i at [i*COORD_W +: COORD_W]
//   rect_w/h     packed sizes, same packing
//   tdata        {R,G,B}, each CH_W bits
//   tvalid       stream valid
//   tready       stream ready
//   tuser        start of frame (pixel 0,0)
//   tlast        end of line (x = H_ACTIVE-1)
//   busy         a frame is in progress (including its last pending beat)
//   frame_done   one-cycle pulse after the final beat of a frame handshakes
//   frame_count  completed frames, wraps at 16 bits
//
// Stream handshake: a beat transfers on a rising edge where tvalid and
// tready are both high. Once tvalid is high, tdata/tuser/tlast hold until
// that transfer; the output register only reloads when it is empty
// (tvalid=0) or being drained in the same cycle (tready=1).
// ---------------------------------------------------------------------------
module video_stream_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int COORD_W      = 10,
    parameter int CH_W         = 8,
    parameter int NUM_RECTS    = 2,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic                           pixel_clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [1:0]                     mode,
    input  logic [11:0]                    bg_color,
    input  logic [11:0]                    fg_color,
    input  logic [NUM_RECTS-1:0]           rect_en,
    input  logic [NUM_RECTS*COORD_W-1:0]   rect_x,
    input  logic [NUM_RECTS*COORD_W-1:0]   rect_y,
    input  logic [NUM_RECTS*COORD_W-1:0]   rect_w,
    input  logic [NUM_RECTS*COORD_W-1:0]   rect_h,
    output logic [3*CH_W-1:0]              tdata,
    output logic                           tvalid,
    input  logic                           tready,
    output logic                           tuser,
    output logic                           tlast,
    output logic                           busy,
    output logic                           frame_done,
    output logic [15:0]                    frame_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
    localparam int                 BAR_W  = H_ACTIVE / 8;

    // Replicate a 4-bit channel MSB-first and keep the top CH_W bits.
    function automatic logic [CH_W-1:0] expand(input logic [3:0] nib);
        logic [15:0] rep;
        rep = {4{nib}};
        return rep[15 -: CH_W];
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t                         state_q, state_d;
    logic [COORD_W-1:0]             x_q, x_d;
    logic [COORD_W-1:0]             y_q, y_d;

    logic [1:0]                     mode_q, mode_d;
    logic [11:0]                    bg_q, bg_d;
    logic [11:0]                    fg_q, fg_d;
    logic [NUM_RECTS-1:0]           rect_en_q, rect_en_d;
    logic [NUM_RECTS*COORD_W-1:0]   rect_x_q, rect_x_d;
    logic [NUM_RECTS*COORD_W-1:0]   rect_y_q, rect_y_d;
    logic [NUM_RECTS*COORD_W-1:0]   rect_w_q, rect_w_d;
    logic [NUM_RECTS*COORD_W-1:0]   rect_h_q, rect_h_d;

    logic [3*CH_W-1:0]              tdata_q, tdata_d;
    logic                           tvalid_q, tvalid_d;
    logic                           tuser_q, tuser_d;
    logic                           tlast_q, tlast_d;
    // Marks that the beat in the output register is the frame's last pixel.
    logic                           eof_q, eof_d;
    logic                           busy_q, busy_d;
    logic                           frame_done_q, frame_done_d;
    logic [15:0]                    frame_count_q, frame_count_d;

    // ------------------------------------------------------------------
    // Pixel colour from the latched configuration at (x_q, y_q)
    // ------------------------------------------------------------------
    logic [NUM_RECTS-1:0] rect_hit;

    for (genvar i = 0; i < NUM_RECTS; i++) begin : g_rect
        logic [COORD_W:0] rx, ry, rx_end, ry_end;
        // One extra bit so rx+rw never wraps; rects hanging off the
        // screen simply stop matching at the edge.
        assign rx     = {1'b0, rect_x_q[i*COORD_W +: COORD_W]};
        assign ry     = {1'b0, rect_y_q[i*COORD_W +: COORD_W]};
        assign rx_end = rx + {1'b0, rect_w_q[i*COORD_W +: COORD_W]};
        assign ry_end = ry + {1'b0, rect_h_q[i*COORD_W +: COORD_W]};
        // A zero width or height makes the half-open interval empty.
        assign rect_hit[i] = rect_en_q[i]
                           && ({1'b0, x_q} >= rx) && ({1'b0, x_q} < rx_end)
                           && ({1'b0, y_q} >= ry) && ({1'b0, y_q} < ry_end);
    end

    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    logic [11:0] pix_rgb;

    always_comb begin
        // Bar index is the number of bar boundaries at or left of x,
        // which saturates at 7 when H_ACTIVE is not a multiple of 8.
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x_q) >= k * BAR_W) begin
                bar_idx = 3'(k);
            end
        end

        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase

        case (mode_q)
            2'd0:    pix_rgb = bg_q;
            2'd1:    pix_rgb = (|rect_hit) ? fg_q : bg_q;
            2'd2:    pix_rgb = bar_rgb;
            default: pix_rgb = (x_q[CHECKER_LOG2] ^ y_q[CHECKER_LOG2]) ? fg_q : bg_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic slot_free;
    logic load;
    logic last_pix;
    logic latch_cfg;

    always_comb begin
        slot_free = !tvalid_q || tready;
        load      = (state_q == S_RUN) && slot_free;
        last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        latch_cfg     = 1'b0;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tuser_d       = tuser_q;
        tlast_d       = tlast_q;
        eof_d         = eof_q;

        case (state_q)
            S_IDLE: begin
                if (enable && slot_free) begin
                    latch_cfg = 1'b1;
                    state_d   = S_RUN;
                end
            end
            default: begin
                // The next frame's configuration is captured on the same
                // edge that loads the last pixel, so frames run back to back.
                if (load && last_pix) begin
                    if (enable) begin
                        latch_cfg = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        mode_d    = latch_cfg ? mode     : mode_q;
        bg_d      = latch_cfg ? bg_color : bg_q;
        fg_d      = latch_cfg ? fg_color : fg_q;
        rect_en_d = latch_cfg ? rect_en  : rect_en_q;
        rect_x_d  = latch_cfg ? rect_x   : rect_x_q;
        rect_y_d  = latch_cfg ? rect_y   : rect_y_q;
        rect_w_d  = latch_cfg ? rect_w   : rect_w_q;
        rect_h_d  = latch_cfg ? rect_h   : rect_h_q;

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = {expand(pix_rgb[11:8]), expand(pix_rgb[7:4]), expand(pix_rgb[3:0])};
            tuser_d  = (x_q == '0) && (y_q == '0);
            tlast_d  = (x_q == X_LAST);
            eof_d    = last_pix;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (tready) begin
            tvalid_d = 1'b0;
        end

        frame_done_d  = tvalid_q && tready && eof_q;
        frame_count_d = frame_count_q + 16'(frame_done_d);
        // Busy covers the running frame and its final beat until it drains.
        busy_d        = (state_d == S_RUN) || tvalid_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            mode_q        <= '0;
            bg_q          <= '0;
            fg_q          <= '0;
            rect_en_q     <= '0;
            rect_x_q      <= '0;
            rect_y_q      <= '0;
            rect_w_q      <= '0;
            rect_h_q      <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            eof_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mode_q        <= mode_d;
            bg_q          <= bg_d;
            fg_q          <= fg_d;
            rect_en_q     <= rect_en_d;
            rect_x_q      <= rect_x_d;
            rect_y_q      <= rect_y_d;
            rect_w_q      <= rect_w_d;
            rect_h_q      <= rect_h_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            eof_q         <= eof_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tdata       = tdata_q;
    assign tvalid      = tvalid_q;
    assign tuser       = tuser_q;
    assign tlast       = tlast_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_video_stream_gen
//
// Directed bench for video_stream_gen on a reduced 36x8 raster (bar width 4,
// so x = 32..35 lands on the saturated last bar), 2 rectangles, 2-pixel
// checker squares. A negedge monitor follows every beat, tracks the
// expected raster position and checks pixel colour, tuser/tlast, hold
// stability under stall, frame_done timing and frame_count. Directed spot
// checks against hand-computed colours are made on the captured frames.
// ---------------------------------------------------------------------------
module tb_video_stream_gen;

    localparam int H   = 36;
    localparam int V   = 8;
    localparam int CW  = 6;
    localparam int CHW = 8;
    localparam int NR  = 2;
    localparam int CL  = 1;

    // clock / reset ------------------------------------------------------
    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 pixel_clk = ~pixel_clk;

    logic              enable = 1'b0;
    logic [1:0]        mode = '0;
    logic [11:0]       bg_color = '0;
    logic [11:0]       fg_color = '0;
    logic [NR-1:0]     rect_en = '0;
    logic [NR*CW-1:0]  rect_x = '0;
    logic [NR*CW-1:0]  rect_y = '0;
    logic [NR*CW-1:0]  rect_w = '0;
    logic [NR*CW-1:0]  rect_h = '0;
    logic [3*CHW-1:0]  tdata;
    logic              tvalid;
    logic              tready = 1'b1;
    logic              tuser;
    logic              tlast;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_count;

    video_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .CH_W(CHW),
        .NUM_RECTS(NR), .CHECKER_LOG2(CL)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .mode(mode),
        .bg_color(bg_color), .fg_color(fg_color), .rect_en(rect_en),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tuser(tuser),
        .tlast(tlast), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    // scoreboard state ---------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // expected configuration for the frame in flight
    int          e_mode;
    logic [11:0] e_bg, e_fg;
    logic [1:0]  e_ren;
    int          e_rx[NR], e_ry[NR], e_rw[NR], e_rh[NR];
    logic [11:0] bar_tab[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [23:0] exp_pix(input int x, input int y);
        logic [11:0] c;
        int idx;
        bit hit;
        c = e_bg;
        case (e_mode)
            0: c = e_bg;
            1: begin
                hit = 0;
                for (int i = 0; i < NR; i++)
                    if (e_ren[i] && x >= e_rx[i] && x < e_rx[i] + e_rw[i] &&
                        y >= e_ry[i] && y < e_ry[i] + e_rh[i]) hit = 1;
                c = hit ? e_fg : e_bg;
            end
            2: begin
                idx = x / (H / 8);
                if (idx > 7) idx = 7;
                c = bar_tab[idx];
            end
            default: c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? e_fg : e_bg;
        endcase
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

    // monitor ------------------------------------------------------------
    bit          mon_en = 0;
    bit          ready_rand = 0;
    int          cyc = 0;
    int          mon_x = 0, mon_y = 0;
    int          last_eof_cyc = -100;
    int          last_gap = 0;
    int          exp_frames = 0;
    int          beats = 0, sof_cnt = 0, eol_cnt = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_data;
    logic        prev_user, prev_last;
    logic [23:0] pix_mem[V][H];

    always @(posedge pixel_clk) begin
        #1;
        tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge pixel_clk) begin
        if (!reset && mon_en) begin
            cyc++;
            check("frame_done", 32'(frame_done), 32'(cyc == last_eof_cyc + 1));
            check("frame_count", 32'(frame_count), 32'(exp_frames & 16'hFFFF));
            if (prev_stall) begin
                check("hold_valid", 32'(tvalid), 32'd1);
                check("hold_data", 32'(tdata), 32'(prev_data));
                check("hold_user", 32'(tuser), 32'(prev_user));
                check("hold_last", 32'(tlast), 32'(prev_last));
            end
            if (tvalid && tready) begin
                check("pix", 32'(tdata), 32'(exp_pix(mon_x, mon_y)));
                check("tuser", 32'(tuser), 32'(mon_x == 0 && mon_y == 0));
                check("tlast", 32'(tlast), 32'(mon_x == H - 1));
                pix_mem[mon_y][mon_x] = tdata;
                beats++;
                if (tuser) sof_cnt++;
                if (tlast) eol_cnt++;
                if (mon_x == 0 && mon_y == 0) last_gap = cyc - last_eof_cyc;
                if (mon_x == H - 1 && mon_y == V - 1) begin
                    last_eof_cyc = cyc;
                    exp_frames++;
                end
                if (mon_x == H - 1) begin
                    mon_x = 0;
                    mon_y = (mon_y == V - 1) ? 0 : mon_y + 1;
                end else begin
                    mon_x++;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_user  = tuser;
            prev_last  = tlast;
        end
    end

    // driver tasks -------------------------------------------------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic apply_cfg();
        mode     = 2'(e_mode);
        bg_color = e_bg;
        fg_color = e_fg;
        rect_en  = e_ren;
        rect_x   = {6'(e_rx[1]), 6'(e_rx[0])};
        rect_y   = {6'(e_ry[1]), 6'(e_ry[0])};
        rect_w   = {6'(e_rw[1]), 6'(e_rw[0])};
        rect_h   = {6'(e_rh[1]), 6'(e_rh[0])};
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        check({tag, "_busy_timeout"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_done_timeout"}, 32'(frame_done), 32'd1);
    endtask

    // Runs one frame with the current e_* configuration. When mutate is
    // set, rect0's x input is moved right after the frame starts.
    task automatic run_frame(input string tag, input bit mutate);
        beats = 0; sof_cnt = 0; eol_cnt = 0;
        apply_cfg();
        enable = 1'b1;
        wait_busy(tag);
        enable = 1'b0;
        if (mutate) rect_x = {6'(e_rx[1]), 6'd20};
        wait_done(tag);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        tick(3);
        check({tag, "_beats"}, 32'(beats), 32'(H * V));
        check({tag, "_sof"}, 32'(sof_cnt), 32'd1);
        check({tag, "_eol"}, 32'(eol_cnt), 32'(V));
        check({tag, "_tvalid_idle"}, 32'(tvalid), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tuser"}, 32'(tuser), 32'd0);
        check({tag, "_tlast"}, 32'(tlast), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_tdata"}, 32'(tdata), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // stimulus -----------------------------------------------------------
    initial begin
        e_mode = 0; e_bg = 12'h000; e_fg = 12'h000; e_ren = 2'b00;
        for (int i = 0; i < NR; i++) begin
            e_rx[i] = 0; e_ry[i] = 0; e_rw[i] = 0; e_rh[i] = 0;
        end
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        mon_en = 1;
        tick(2);

        // solid background, continuous ready
        e_mode = 0; e_bg = 12'hF00;
        run_frame("solid", 0);
        check("solid_px_0_0", 32'(pix_mem[0][0]), 32'hFF0000);
        check("solid_px_35_7", 32'(pix_mem[7][35]), 32'hFF0000);
        check("solid_count", 32'(frame_count), 32'd1);

        // rect0 at (10,2) size 5x3; rect1 configured but disabled;
        // rect0 x input moved mid-frame must not affect this frame
        e_mode = 1; e_fg = 12'h0FF; e_bg = 12'hF00; e_ren = 2'b01;
        e_rx[0] = 10; e_ry[0] = 2; e_rw[0] = 5;  e_rh[0] = 3;
        e_rx[1] = 33; e_ry[1] = 6; e_rw[1] = 10; e_rh[1] = 10;
        run_frame("rect", 1);
        check("rect_in_10_2", 32'(pix_mem[2][10]), 32'h00FFFF);
        check("rect_in_14_4", 32'(pix_mem[4][14]), 32'h00FFFF);
        check("rect_out_15_4", 32'(pix_mem[4][15]), 32'hFF0000);
        check("rect_out_9_3", 32'(pix_mem[3][9]), 32'hFF0000);
        check("rect_out_10_5", 32'(pix_mem[5][10]), 32'hFF0000);
        check("rect_dis_35_7", 32'(pix_mem[7][35]), 32'hFF0000);

        // moved rect0 takes effect now; rect1 enabled and clipped at edge
        e_rx[0] = 20; e_ren = 2'b11;
        run_frame("rect2", 0);
        check("rect2_new_20_2", 32'(pix_mem[2][20]), 32'h00FFFF);
        check("rect2_old_10_2", 32'(pix_mem[2][10]), 32'hFF0000);
        check("rect2_clip_35_7", 32'(pix_mem[7][35]), 32'h00FFFF);
        check("rect2_clip_33_6", 32'(pix_mem[6][33]), 32'h00FFFF);
        check("rect2_out_32_7", 32'(pix_mem[7][32]), 32'hFF0000);

        // colour bars under random backpressure
        e_mode = 2; e_ren = 2'b00;
        ready_rand = 1;
        run_frame("bars", 0);
        check("bar0_3", 32'(pix_mem[0][3]), 32'hFFFFFF);
        check("bar1_4", 32'(pix_mem[0][4]), 32'hFFFF00);
        check("bar2_8", 32'(pix_mem[1][8]), 32'h00FFFF);
        check("bar3_12", 32'(pix_mem[2][12]), 32'h00FF00);
        check("bar4_16", 32'(pix_mem[3][16]), 32'hFF00FF);
        check("bar5_20", 32'(pix_mem[4][20]), 32'hFF0000);
        check("bar6_24", 32'(pix_mem[5][24]), 32'h0000FF);
        check("bar7_28", 32'(pix_mem[6][28]), 32'h000000);
        check("bar_sat_35", 32'(pix_mem[7][35]), 32'h000000);

        // checkerboard with 2-pixel squares, random backpressure
        e_mode = 3; e_fg = 12'hA5C; e_bg = 12'h123;
        run_frame("checker", 0);
        check("chk_0_0", 32'(pix_mem[0][0]), 32'h112233);
        check("chk_1_1", 32'(pix_mem[1][1]), 32'h112233);
        check("chk_2_0", 32'(pix_mem[0][2]), 32'hAA55CC);
        check("chk_0_2", 32'(pix_mem[2][0]), 32'hAA55CC);
        check("chk_2_2", 32'(pix_mem[2][2]), 32'h112233);
        check("chk_4_0", 32'(pix_mem[0][4]), 32'h112233);
        ready_rand = 0;
        tick(2);

        // back-to-back frames: enable held across the frame boundary
        e_mode = 0; e_bg = 12'h0F0;
        apply_cfg();
        enable = 1'b1;
        wait_busy("b2b");
        wait_done("b2b_first");
        enable = 1'b0;
        tick(2);
        check("b2b_gap", 32'(last_gap), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b_second");
        tick(3);
        check("b2b_count", 32'(frame_count), 32'd7);
        check("b2b_idle", 32'(tvalid), 32'd0);

        // reset mid-line with a beat in the output register
        e_mode = 2;
        apply_cfg();
        enable = 1'b1;
        beats = 0;
        for (int n = 0; n < 200 && beats < 50; n++) tick(1);
        check("mid_tvalid_pre", 32'(tvalid), 32'd1);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        mon_x = 0; mon_y = 0; exp_frames = 0; last_eof_cyc = -100;
        prev_stall = 0;
        tick(2);
        reset = 1'b0;
        run_frame("after_reset", 0);
        check("after_reset_px_0_0", 32'(pix_mem[0][0]), 32'hFFFFFF);
        check("after_reset_count", 32'(frame_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
